call_ret_ctrl: RTL and testbench
================================

CALL_RET_CTRL -- requirements
Module: call_ret_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock, shared with the return-address stack.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 call  input  1  current instruction is JAL; pc+1 is to be pushed.
REQ-005 ret  input  1  current instruction is JR $ra; an address is to be popped.
REQ-006 pc  input  12  current instruction address.
REQ-007 target  input  12  JAL jump target.
REQ-008 stk_rdata  input  12  stack data_out, the current top entry.
REQ-009 stk_push  output  1  push strobe to the stack.
REQ-010 stk_pop  output  1  pop strobe to the stack.
REQ-011 stk_wdata  output  12  push data to the stack.
REQ-012 next_pc  output  12  redirect address, valid when redirect=1.
REQ-013 redirect  output  1  the PC shall take next_pc this cycle.
REQ-014 depth  output  4  live entry count, 0..8.
REQ-015 fault  output  1  sticky overflow/underflow indication.

Function
REQ-016 The block SHALL drive the stack: states RUN and HALT, with depth as a registered counter.
REQ-017 In RUN with call=1, the block SHALL assert stk_push=1, stk_wdata=pc+1 (mod 2^12), next_pc=target and redirect=1 in the same cycle (combinational). depth SHALL increment at the edge.
REQ-018 In RUN with ret=1 and call=0, the block SHALL assert stk_pop=1, next_pc=stk_rdata and redirect=1 in the same cycle. depth SHALL decrement at the edge.
REQ-019 When call=1 and ret=1, call SHALL take priority and ret SHALL be ignored, matching the stack's push-over-pop priority.
REQ-020 With neither call nor ret, the block SHALL hold stk_push=stk_pop=redirect=0 and next_pc=0, and depth SHALL be unchanged.
REQ-021 Overflow is call at depth=8: the block SHALL suppress stk_push, assert redirect with next_pc=target, set fault and enter HALT; depth SHALL stay 8.
REQ-022 Underflow is ret at depth=0: the block SHALL suppress stk_pop, assert redirect=0, set fault and enter HALT; depth SHALL stay 0.
REQ-023 In HALT, stk_push, stk_pop and redirect SHALL be 0 regardless of call/ret, and depth SHALL be frozen. Only rst SHALL exit HALT.
REQ-024 Back-to-back call then ret SHALL return the just-pushed pc+1 with no bubble.
REQ-025 stk_wdata SHALL be pc+1 whenever call=1, including a suppressed overflow push.

Reset
REQ-026 rst SHALL set state=RUN, depth=0 and fault=0, and all strobes SHALL be 0 in the reset cycle.
REQ-027 rst asserted while call or ret is high SHALL discard the operation and produce no strobe.
REQ-028 Reset SHALL NOT clear stack contents. A depth of 0 after reset SHALL make stale entries unreachable.

Configuration
REQ-029 The macro RAS_FAULT_CHECK_EN SHALL select the behaviour of REQ-021 to REQ-023.
REQ-030 With RAS_FAULT_CHECK_EN defined, REQ-021 to REQ-023 SHALL apply.
REQ-031 Without RAS_FAULT_CHECK_EN, HALT and fault logic SHALL be absent and fault SHALL be tied to 0.
REQ-032 Without RAS_FAULT_CHECK_EN, depth SHALL count modulo 8 (bit 3 always 0), every call SHALL push and every ret SHALL pop, with wrap-around overwriting the oldest entry.

Structure
REQ-033 Shared package SHALL hold ADDR_W=12, RAS_DEPTH=8, DEPTH_W=4 and the state enum {RUN, HALT}.
REQ-034 One sub-module, ras_depth_ctr, SHALL contain the saturating/wrapping up-down counter with full/empty decode.
REQ-035 The stack itself SHALL remain external, connected only via stk_* ports.

Verification
REQ-036 Reset, then call with pc=0x010, target=0x200 -> stk_push=1, stk_wdata=0x011, next_pc=0x200; depth=1 after the edge.
REQ-037 Push 0x011, then the next cycle ret=1 -> stk_pop=1, next_pc=0x011, redirect=1; depth=0.
REQ-038 Nine calls with pc=0x000..0x008 (checks on) -> eight pushes, ninth stk_push=0, fault=1, HALT; a later ret gives no strobe.
REQ-039 ret at depth=0 after reset -> redirect=0, stk_pop=0, fault=1; rst clears fault and depth.
REQ-040 call=1 and ret=1 together with pc=0xFFF -> push only, stk_wdata=0x000, depth +1.
REQ-041 Checks off, nine calls -> depth sequence 1..7,0,1, fault=0, nine stk_push pulses.

Source files
------------

// File: rtl/call_ret_ctrl_pkg.sv
// Shared types and constants for the call/return controller and its
// return-address-stack depth counter.
package call_ret_ctrl_pkg;

  localparam int ADDR_W    = 12;
  localparam int RAS_DEPTH = 8;
  localparam int DEPTH_W   = 4;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } ras_state_e;

  // Plain vector encodings of the state enum for the FSM register.
  localparam logic [0:0] ST_RUN  = RUN;
  localparam logic [0:0] ST_HALT = HALT;

  // Return address of a JAL: the following instruction, wrapping at 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] ret_addr(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/call_ret_ctrl_if.sv
// Bundle of the CPU-side (call/ret/pc/target, redirect) and stack-side
// (stk_*) signals of the call/return controller.
// master: the environment (core front end plus the external stack).
// slave:  the controller.
interface call_ret_ctrl_if;
  import call_ret_ctrl_pkg::*;

  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] stk_rdata;
  logic              stk_push;
  logic              stk_pop;
  logic [ADDR_W-1:0] stk_wdata;
  logic [ADDR_W-1:0] next_pc;
  logic              redirect;

  modport master (
    output call, ret, pc, target, stk_rdata,
    input  stk_push, stk_pop, stk_wdata, next_pc, redirect
  );

  modport slave (
    input  call, ret, pc, target, stk_rdata,
    output stk_push, stk_pop, stk_wdata, next_pc, redirect
  );

endinterface

// File: rtl/call_ret_ctrl_ras_depth_ctr.sv
// Live-entry counter for the return-address stack with full/empty decode.
// Build option RAS_FAULT_CHECK_EN: when defined the counter saturates at
// 0..RAS_DEPTH; otherwise it wraps modulo RAS_DEPTH (top bit stays 0),
// tracking a stack that silently overwrites its oldest entry.
module ras_depth_ctr
  import call_ret_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               dec,
  output logic [DEPTH_W-1:0] depth,
  output logic               full,
  output logic               empty
);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(RAS_DEPTH);

  // Full/empty decode from the registered count.
  always_comb begin
    full  = (depth == DEPTH_MAX);
    empty = (depth == '0);
  end

`ifdef RAS_FAULT_CHECK_EN
  // Saturating up/down count; simultaneous inc and dec cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      depth <= '0;
    end else if (inc && !dec) begin
      if (!full) depth <= depth + DEPTH_W'(1);
    end else if (dec && !inc) begin
      if (!empty) depth <= depth - DEPTH_W'(1);
    end
  end
`else
  // Wrapping count in the low bits; the top bit is held at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      depth <= '0;
    end else if (inc && !dec) begin
      depth <= {1'b0, depth[DEPTH_W-2:0] + (DEPTH_W-1)'(1)};
    end else if (dec && !inc) begin
      depth <= {1'b0, depth[DEPTH_W-2:0] - (DEPTH_W-1)'(1)};
    end
  end
`endif

endmodule

// File: rtl/call_ret_ctrl.sv
// Call/return controller: turns JAL / JR $ra decode into push/pop strobes
// for an external return-address stack and redirects the PC.
// Build option RAS_FAULT_CHECK_EN: when defined, overflow (call at full)
// and underflow (ret at empty) set a sticky fault and park the block in
// HALT until reset. When undefined there is no FSM, fault is tied low and
// the stack depth wraps.
module call_ret_ctrl
  import call_ret_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  call_ret_ctrl_if.slave     bus,
  output logic [DEPTH_W-1:0] depth,
  output logic               fault
);

  logic go;
  logic do_call;
  logic do_ret;
  logic push;
  logic pop;
  logic full;
  logic empty;

`ifdef RAS_FAULT_CHECK_EN
  logic [0:0] state;
  logic       ovf;
  logic       unf;
`else
  logic       unused_flags;
`endif

  ras_depth_ctr u_depth (
    .clk   (clk),
    .rst   (rst),
    .inc   (push),
    .dec   (pop),
    .depth (depth),
    .full  (full),
    .empty (empty)
  );

  // Qualify call/ret: reset discards the operation, call wins over ret,
  // and the stack is only touched when it can take the operation.
  always_comb begin
`ifdef RAS_FAULT_CHECK_EN
    go      = !rst && (state == ST_RUN);
`else
    go      = !rst;
`endif
    do_call = go && bus.call;
    do_ret  = go && bus.ret && !bus.call;
`ifdef RAS_FAULT_CHECK_EN
    push    = do_call && !full;
    pop     = do_ret && !empty;
    ovf     = do_call && full;
    unf     = do_ret && empty;
`else
    push    = do_call;
    pop     = do_ret;
`endif
  end

  // Stack strobes and PC redirect. A call still redirects to its target
  // even when its push is suppressed; a suppressed pop does not redirect.
  always_comb begin
    bus.stk_push  = push;
    bus.stk_pop   = pop;
    bus.stk_wdata = ret_addr(bus.pc);
    bus.redirect  = do_call || pop;
    if (do_call)  bus.next_pc = bus.target;
    else if (pop) bus.next_pc = bus.stk_rdata;
    else          bus.next_pc = '0;
  end

`ifdef RAS_FAULT_CHECK_EN
  // RUN/HALT state with sticky fault; only reset leaves HALT.
  //   state | meaning
  //   RUN   | normal operation, strobes follow call/ret
  //   HALT  | overflow/underflow seen, all strobes held low
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      fault <= 1'b0;
    end else if ((state == ST_RUN) && (ovf || unf)) begin
      state <= ST_HALT;
      fault <= 1'b1;
    end
  end
`else
  // Without fault checking the flags have no consumer.
  always_comb begin
    fault        = 1'b0;
    unused_flags = full ^ empty;
  end
`endif

endmodule

// File: tb/tb_call_ret_ctrl.sv
// Self-checking bench for call_ret_ctrl. Models the external return-address
// stack, predicts every cycle's strobes/redirect/depth/fault from an
// independent reference model and compares via a scoreboard queue.
// Follows RAS_FAULT_CHECK_EN the same way the design does.
module tb_call_ret_ctrl;
  import call_ret_ctrl_pkg::*;

`ifdef RAS_FAULT_CHECK_EN
  localparam bit CHECKS = 1'b1;
`else
  localparam bit CHECKS = 1'b0;
`endif

  typedef struct {
    logic        push;
    logic        pop;
    logic        redirect;
    logic [11:0] next_pc;
    logic [11:0] wdata;
    logic        chk_npc;
    logic [3:0]  depth;
    logic        fault;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] depth;
  logic       fault;

  call_ret_ctrl_if bus ();

  call_ret_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .depth (depth),
    .fault (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External stack: contents survive reset, pointer does not.
  logic [11:0] stk_mem [8];
  logic [2:0]  stk_sp;
  initial for (int i = 0; i < 8; i++) stk_mem[i] = 12'h000;
  assign bus.stk_rdata = stk_mem[stk_sp - 3'd1];
  always @(posedge clk) begin
    if (rst) begin
      stk_sp <= 3'd0;
    end else if (bus.stk_push) begin
      stk_mem[stk_sp] <= bus.stk_wdata;
      stk_sp          <= stk_sp + 3'd1;
    end else if (bus.stk_pop) begin
      stk_sp <= stk_sp - 3'd1;
    end
  end

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q [$];

  // Reference model state.
  int          m_depth = 0;
  bit          m_halt  = 1'b0;
  bit          m_fault = 1'b0;
  logic [11:0] ret_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic exp_t predict(input logic r, input logic c, input logic t,
                                   input logic [11:0] p, input logic [11:0] tg);
    exp_t e;
    e.push = 1'b0; e.pop = 1'b0; e.redirect = 1'b0; e.next_pc = 12'h000;
    e.wdata = p + 12'h001; e.chk_npc = 1'b1;
    if (r) begin
      m_depth = 0; m_halt = 1'b0; m_fault = 1'b0;
      ret_q.delete();
    end else if (CHECKS && m_halt) begin
      // frozen
    end else if (c) begin
      e.redirect = 1'b1;
      e.next_pc  = tg;
      if (CHECKS && m_depth == 8) begin
        m_halt = 1'b1; m_fault = 1'b1;
      end else begin
        e.push = 1'b1;
        ret_q.push_back(p + 12'h001);
        if (ret_q.size() > 8) ret_q.delete(0);
        m_depth = CHECKS ? m_depth + 1 : (m_depth + 1) % 8;
      end
    end else if (t) begin
      if (CHECKS && m_depth == 0) begin
        m_halt = 1'b1; m_fault = 1'b1;
      end else begin
        e.pop = 1'b1;
        e.redirect = 1'b1;
        if (ret_q.size() > 0) e.next_pc = ret_q.pop_back();
        else                  e.chk_npc = 1'b0;
        m_depth = CHECKS ? m_depth - 1 : (m_depth + 7) % 8;
      end
    end
    e.depth = 4'(m_depth);
    e.fault = m_fault;
    return e;
  endfunction

  task automatic drive(input logic r, input logic c, input logic t,
                       input logic [11:0] p, input logic [11:0] tg);
    exp_t e;
    @(negedge clk);
    rst = r; bus.call = c; bus.ret = t; bus.pc = p; bus.target = tg;
    exp_q.push_back(predict(r, c, t, p, tg));
    #1;
    e = exp_q.pop_front();
    check("stk_push", bus.stk_push, e.push);
    check("stk_pop",  bus.stk_pop,  e.pop);
    check("redirect", bus.redirect, e.redirect);
    check("stk_wdata", bus.stk_wdata, e.wdata);
    if (e.chk_npc) check("next_pc", bus.next_pc, e.next_pc);
    @(posedge clk);
    #1;
    check("depth", depth, e.depth);
    check("fault", fault, e.fault);
  endtask

  initial begin
    rst = 1'b1; bus.call = 1'b0; bus.ret = 1'b0; bus.pc = '0; bus.target = '0;

    // Reset cycles, including reset with call/ret high.
    drive(1, 0, 0, 12'h000, 12'h000);
    drive(1, 1, 1, 12'h123, 12'h456);
    drive(1, 0, 1, 12'h000, 12'h000);

    // Call then immediate return.
    drive(0, 1, 0, 12'h010, 12'h200);
    drive(0, 0, 1, 12'h200, 12'h000);
    drive(0, 0, 0, 12'h201, 12'h000);

    // call+ret together at pc wrap: push only, returns 0x000.
    drive(0, 1, 1, 12'hFFF, 12'h300);
    drive(0, 0, 1, 12'h300, 12'h000);

    // Nested calls and returns back to back.
    drive(0, 1, 0, 12'h100, 12'h400);
    drive(0, 1, 0, 12'h400, 12'h500);
    drive(0, 1, 0, 12'h500, 12'h600);
    drive(0, 0, 1, 12'h600, 12'h000);
    drive(0, 1, 0, 12'h501, 12'h700);
    drive(0, 0, 1, 12'h700, 12'h000);
    drive(0, 0, 1, 12'h502, 12'h000);
    drive(0, 0, 1, 12'h401, 12'h000);

    // ret at depth 0 (underflow or wrap), then reset clears it.
    drive(0, 0, 1, 12'h050, 12'h000);
    drive(0, 1, 0, 12'h051, 12'h060);
    drive(1, 0, 0, 12'h000, 12'h000);
    drive(0, 0, 0, 12'h000, 12'h000);

    // Nine calls: overflow or wrap, then a ret.
    for (int i = 0; i < 9; i++) drive(0, 1, 0, 12'(i), 12'(12'h800 + i));
    drive(0, 0, 1, 12'h900, 12'h000);
    drive(0, 1, 0, 12'h901, 12'h000);
    drive(1, 0, 0, 12'h000, 12'h000);

    // Random traffic with occasional reset.
    for (int i = 0; i < 150; i++) begin
      logic r, c, t;
      r = ($urandom_range(0, 24) == 0);
      c = ($urandom_range(0, 2) == 0);
      t = ($urandom_range(0, 2) == 0);
      drive(r, c, t, 12'($urandom), 12'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
